// File: rtl/motor_seq_pkg.sv
// motor_seq_pkg
// Shared types and constants for the motor command sequencer.
//   chan_state_t         : per-channel bridge state (OFF, RUN, DEAD)
//   CMD_DIR_BIT          : direction bit inside a command byte (1 = forward)
//   CMD_DUTY_MSB         : top bit of the duty field, [CMD_DUTY_MSB:0]
//   FWD/REV/COAST/BRAKE  : bridge input encodings, {a_hi, a_lo}
package motor_seq_pkg;

    typedef enum logic [1:0] {
        OFF  = 2'd0,
        RUN  = 2'd1,
        DEAD = 2'd2
    } chan_state_t;

    localparam int CMD_DIR_BIT  = 7;
    localparam int CMD_DUTY_MSB = 6;

    localparam logic [1:0] FWD   = 2'b10;
    localparam logic [1:0] REV   = 2'b01;
    localparam logic [1:0] COAST = 2'b00;
    localparam logic [1:0] BRAKE = 2'b11;

endpackage

// File: rtl/motor_seq_channel.sv
// motor_seq_channel
// One H-bridge channel: OFF/RUN/DEAD state machine, dead-time counter and
// the currently applied direction/duty. Outputs are registered and are
// computed from the next state and the next PWM count, so they line up with
// the state the channel is in during that cycle.
// Optional feature: MOTOR_SEQ_BRAKE_EN -- when defined, a channel that went
// OFF because of a duty=0 command actively brakes (enable=1, bridge=11).
// Ports:
//   clk, reset   : clock, synchronous active-high reset
//   i_boundary   : high in the PWM wrap cycle (period boundary)
//   i_pwm_cnt    : shared PWM counter
//   i_pend_cmd   : pending command byte for this channel
//   i_force_off  : forces OFF with coasting outputs (watchdog fault)
//   o_enable     : bridge PWM enable
//   o_bridge     : bridge direction inputs {a_hi, a_lo}
module motor_seq_channel #(
    parameter int PWM_BITS        = 7,
    parameter int DEADTIME_CYCLES = 64
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                i_boundary,
    input  logic [PWM_BITS-1:0] i_pwm_cnt,
    input  logic [7:0]          i_pend_cmd,
    input  logic                i_force_off,
    output logic                o_enable,
    output logic [1:0]          o_bridge
);
    import motor_seq_pkg::*;

    localparam int DUTY_W = CMD_DUTY_MSB + 1;
    localparam int DEAD_W = (DEADTIME_CYCLES > 1) ? $clog2(DEADTIME_CYCLES) : 1;
    localparam logic [DEAD_W-1:0] DEAD_LAST = DEAD_W'(DEADTIME_CYCLES - 1);

`ifdef MOTOR_SEQ_BRAKE_EN
    localparam bit BRAKE_EN = 1'b1;
`else
    localparam bit BRAKE_EN = 1'b0;
`endif

    chan_state_t         r_state, w_state_next;
    logic [DEAD_W-1:0]   r_dead_cnt, w_dead_cnt_next;
    logic                r_dir, w_dir_next;
    logic [DUTY_W-1:0]   r_duty, w_duty_next;
    logic                r_brake, w_brake_next;   // OFF entered via a duty=0 command
    logic                r_enable, w_enable_next;
    logic [1:0]          r_bridge, w_bridge_next;
    logic [PWM_BITS-1:0] w_cnt_next;
    logic                w_pend_dir;
    logic [DUTY_W-1:0]   w_pend_duty;

    assign w_pend_dir  = i_pend_cmd[CMD_DIR_BIT];
    assign w_pend_duty = i_pend_cmd[CMD_DUTY_MSB:0];
    // PWM count seen during the cycle the registered outputs will be valid
    assign w_cnt_next  = i_boundary ? '0 : i_pwm_cnt + PWM_BITS'(1);

    always_comb begin
        w_state_next    = r_state;
        w_dead_cnt_next = r_dead_cnt;
        w_dir_next      = r_dir;
        w_duty_next     = r_duty;
        w_brake_next    = r_brake;
        w_enable_next   = 1'b0;
        w_bridge_next   = COAST;

        if (i_force_off) begin
            w_state_next    = OFF;
            w_dead_cnt_next = '0;
            w_brake_next    = 1'b0;
        end else begin
            case (r_state)
                OFF: begin
                    if (i_boundary && (w_pend_duty != '0)) begin
                        w_state_next = RUN;
                        w_dir_next   = w_pend_dir;
                        w_duty_next  = w_pend_duty;
                        w_brake_next = 1'b0;
                    end
                end
                RUN: begin
                    if (i_boundary) begin
                        if (w_pend_duty == '0) begin
                            w_state_next = OFF;
                            w_brake_next = 1'b1;
                        end else if (w_pend_dir != r_dir) begin
                            w_state_next    = DEAD;
                            w_dead_cnt_next = '0;
                        end else begin
                            w_duty_next = w_pend_duty;
                        end
                    end
                end
                DEAD: begin
                    // Expiry does not wait for a boundary: the new direction
                    // starts mid-period with the latest pending command.
                    if (r_dead_cnt == DEAD_LAST) begin
                        w_dead_cnt_next = '0;
                        if (w_pend_duty == '0) begin
                            w_state_next = OFF;
                            w_brake_next = 1'b1;
                        end else begin
                            w_state_next = RUN;
                            w_dir_next   = w_pend_dir;
                            w_duty_next  = w_pend_duty;
                            w_brake_next = 1'b0;
                        end
                    end else begin
                        w_dead_cnt_next = r_dead_cnt + DEAD_W'(1);
                    end
                end
                default: w_state_next = OFF;
            endcase
        end

        case (w_state_next)
            RUN: begin
                // count never exceeds 2^PWM_BITS-2, so full-scale duty is always on
                w_enable_next = (int'(w_cnt_next) < int'(w_duty_next));
                w_bridge_next = w_dir_next ? FWD : REV;
            end
            OFF: begin
                if (BRAKE_EN && w_brake_next) begin
                    w_enable_next = 1'b1;
                    w_bridge_next = BRAKE;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= OFF;
            r_dead_cnt <= '0;
            r_dir      <= 1'b0;
            r_duty     <= '0;
            r_brake    <= 1'b0;
            r_enable   <= 1'b0;
            r_bridge   <= COAST;
        end else begin
            r_state    <= w_state_next;
            r_dead_cnt <= w_dead_cnt_next;
            r_dir      <= w_dir_next;
            r_duty     <= w_duty_next;
            r_brake    <= w_brake_next;
            r_enable   <= w_enable_next;
            r_bridge   <= w_bridge_next;
        end
    end

    assign o_enable = r_enable;
    assign o_bridge = r_bridge;

endmodule

// File: rtl/motor_cmd_sequencer.sv
// motor_cmd_sequencer
// Applies SPI motor command frames to a two-channel H-bridge at PWM period
// boundaries, with dead-time on reversal and a frame watchdog.
// Optional feature: MOTOR_SEQ_BRAKE_EN (active brake on duty=0 command).
// Ports:
//   clk, reset             : clock, synchronous active-high reset
//   frame_valid            : one-cycle pulse, new motor1_cmd/motor2_cmd
//   motor1_cmd, motor2_cmd : bit7 = direction (1 fwd), [6:0] = duty
//   enable12, a1, a2       : bridge 1 enable and direction inputs
//   enable34, a3, a4       : bridge 2 enable and direction inputs
//   fault, debug_light     : watchdog expired (debug_light mirrors fault)
module motor_cmd_sequencer #(
    parameter int PWM_BITS        = 7,
    parameter int DEADTIME_CYCLES = 64,
    parameter int WDT_CYCLES      = 1_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_valid,
    input  logic [7:0] motor1_cmd,
    input  logic [7:0] motor2_cmd,
    output logic       enable12,
    output logic       a1,
    output logic       a2,
    output logic       enable34,
    output logic       a3,
    output logic       a4,
    output logic       fault,
    output logic       debug_light
);
    localparam logic [PWM_BITS-1:0] PWM_LAST = PWM_BITS'((2 ** PWM_BITS) - 2);
    localparam int WDT_W = (WDT_CYCLES > 1) ? $clog2(WDT_CYCLES) : 1;
    localparam logic [WDT_W-1:0] WDT_LAST = WDT_W'(WDT_CYCLES - 1);

    logic [PWM_BITS-1:0] r_pwm_cnt;
    logic [WDT_W-1:0]    r_wdt_cnt;
    logic                r_fault;
    logic                w_boundary;
    logic                w_wdt_expire;
    logic                w_fault_next;
    logic [7:0]          w_cmd    [2];
    logic                w_enable [2];
    logic [1:0]          w_bridge [2];

    assign w_boundary   = (r_pwm_cnt == PWM_LAST);
    assign w_wdt_expire = !r_fault && (r_wdt_cnt == WDT_LAST);
    // A frame arriving in the expiry cycle wins. Channels and pending
    // registers react to the next fault value so the bridges coast in the
    // same cycle fault becomes visible.
    assign w_fault_next = frame_valid ? 1'b0 : (r_fault | w_wdt_expire);

    assign w_cmd[0] = motor1_cmd;
    assign w_cmd[1] = motor2_cmd;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pwm_cnt <= '0;
            r_wdt_cnt <= '0;
            r_fault   <= 1'b0;
        end else begin
            r_pwm_cnt <= w_boundary ? '0 : r_pwm_cnt + PWM_BITS'(1);
            r_fault   <= w_fault_next;
            if (frame_valid) begin
                r_wdt_cnt <= '0;
            end else if (!r_fault && !w_wdt_expire) begin
                r_wdt_cnt <= r_wdt_cnt + WDT_W'(1);
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_chan
            logic [7:0] r_pend;

            // Latest frame overwrites; a fault wipes any stale command.
            always_ff @(posedge clk) begin
                if (reset) begin
                    r_pend <= '0;
                end else if (frame_valid) begin
                    r_pend <= w_cmd[gi];
                end else if (w_fault_next) begin
                    r_pend <= '0;
                end
            end

            motor_seq_channel #(
                .PWM_BITS        (PWM_BITS),
                .DEADTIME_CYCLES (DEADTIME_CYCLES)
            ) u_chan (
                .clk         (clk),
                .reset       (reset),
                .i_boundary  (w_boundary),
                .i_pwm_cnt   (r_pwm_cnt),
                .i_pend_cmd  (r_pend),
                .i_force_off (w_fault_next),
                .o_enable    (w_enable[gi]),
                .o_bridge    (w_bridge[gi])
            );
        end
    endgenerate

    assign enable12    = w_enable[0];
    assign {a1, a2}    = w_bridge[0];
    assign enable34    = w_enable[1];
    assign {a3, a4}    = w_bridge[1];
    assign fault       = r_fault;
    assign debug_light = r_fault;

endmodule

// File: tb/tb_motor_cmd_sequencer.sv
// tb_motor_cmd_sequencer
// Directed bench for motor_cmd_sequencer with DEADTIME_CYCLES=8 and
// WDT_CYCLES=2000. Expected per-period bridge behaviour is pushed to a
// scoreboard queue when a frame is driven and popped when a whole PWM period
// has been observed. Honours MOTOR_SEQ_BRAKE_EN for the brake expectations.
module tb_motor_cmd_sequencer;

    localparam int PERIOD = 127;
    localparam logic [1:0] FWD   = 2'b10;
    localparam logic [1:0] REV   = 2'b01;
    localparam logic [1:0] COAST = 2'b00;
`ifdef MOTOR_SEQ_BRAKE_EN
    localparam int         BRK_ON = 127;
    localparam logic [1:0] BRK_A  = 2'b11;
`else
    localparam int         BRK_ON = 0;
    localparam logic [1:0] BRK_A  = 2'b00;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       frame_valid;
    logic [7:0] motor1_cmd;
    logic [7:0] motor2_cmd;
    logic       enable12, a1, a2, enable34, a3, a4, fault, debug_light;

    int n_checks = 0;
    int n_errors = 0;
    int tb_pwm   = 0;   // expected PWM phase, restarted by reset

    typedef struct {
        int         on12;
        logic [1:0] a12;
        int         on34;
        logic [1:0] a34;
    } exp_t;
    exp_t sb_q[$];

    motor_cmd_sequencer #(
        .PWM_BITS        (7),
        .DEADTIME_CYCLES (8),
        .WDT_CYCLES      (2000)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .frame_valid (frame_valid),
        .motor1_cmd  (motor1_cmd),
        .motor2_cmd  (motor2_cmd),
        .enable12    (enable12),
        .a1          (a1),
        .a2          (a2),
        .enable34    (enable34),
        .a3          (a3),
        .a4          (a4),
        .fault       (fault),
        .debug_light (debug_light)
    );

    always #5 clk = ~clk;

    always_ff @(posedge clk) begin
        if (reset) tb_pwm <= 0;
        else       tb_pwm <= (tb_pwm == PERIOD - 1) ? 0 : tb_pwm + 1;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input int on12, input logic [1:0] a12, input int on34, input logic [1:0] a34);
        exp_t e;
        e.on12 = on12; e.a12 = a12; e.on34 = on34; e.a34 = a34;
        sb_q.push_back(e);
    endtask

    task automatic send_frame(input logic [7:0] c1, input logic [7:0] c2);
        frame_valid = 1'b1;
        motor1_cmd  = c1;
        motor2_cmd  = c2;
        @(negedge clk);
        frame_valid = 1'b0;
        $display("frame  m1=%02h m2=%02h phase=%0d", c1, c2, tb_pwm);
    endtask

    task automatic wait_phase(input int k);
        int g = 0;
        while (tb_pwm != k && g < 300) begin
            @(negedge clk);
            g++;
        end
        if (g >= 300) begin
            n_errors++;
            $display("FAIL wait_phase: phase %0d not reached", k);
        end
    endtask

    // Observe one full period starting at phase 0 and compare to the oldest
    // scoreboard entry.
    task automatic check_period(input string tag);
        exp_t       e;
        int         on12 = 0, on34 = 0;
        logic [1:0] f12, f34;
        logic       ch12 = 1'b0, ch34 = 1'b0;
        wait_phase(0);
        n_checks++;
        assert (sb_q.size() != 0) else begin
            n_errors++;
            $error("FAIL %s_sb: observed empty scoreboard expected an entry", tag);
            return;
        end
        e   = sb_q.pop_front();
        f12 = {a1, a2};
        f34 = {a3, a4};
        for (int i = 0; i < PERIOD; i++) begin
            on12 += int'(enable12);
            on34 += int'(enable34);
            if ({a1, a2} !== f12) ch12 = 1'b1;
            if ({a3, a4} !== f34) ch34 = 1'b1;
            @(negedge clk);
        end
        $display("period %s on12=%0d a12=%b%s on34=%0d a34=%b%s", tag, on12, f12,
                 ch12 ? "(varied)" : "", on34, f34, ch34 ? "(varied)" : "");
        check({tag, "_on12"}, on12, e.on12);
        check({tag, "_a12"}, {ch12, f12}, {1'b0, e.a12});
        check({tag, "_on34"}, on34, e.on34);
        check({tag, "_a34"}, {ch34, f34}, {1'b0, e.a34});
    endtask

    task automatic wait_fault(input string tag);
        int n = 0;
        while (fault !== 1'b1 && n < 2100) begin
            @(negedge clk);
            n++;
        end
        $display("watchdog %s fault after %0d cycles", tag, n);
        check({tag, "_latency"}, (n >= 1995 && n <= 2005), 1);
    endtask

    initial begin
        int dead_n;
        reset       = 1'b1;
        frame_valid = 1'b0;
        motor1_cmd  = 8'h00;
        motor2_cmd  = 8'h00;
        repeat (3) @(negedge clk);
        check("reset_outputs", {enable12, a1, a2, enable34, a3, a4}, 6'b0);
        check("reset_fault", {fault, debug_light}, 2'b00);
        reset = 1'b0;

        // Forward 10/127 on bridge 1, bridge 2 idle.
        push_exp(10, FWD, 0, COAST);
        send_frame(8'h8A, 8'h00);
        check_period("fwd10");

        // Two frames inside one period: only the last one counts.
        send_frame(8'h85, 8'h00);
        repeat (5) @(negedge clk);
        send_frame(8'hFF, 8'h00);
        push_exp(127, FWD, 0, COAST);
        check_period("last_wins");

        // Frame in the boundary cycle waits one more period.
        wait_phase(PERIOD - 1);
        send_frame(8'hFF, 8'h90);
        push_exp(127, FWD, 0, COAST);
        check_period("bnd_old");
        push_exp(127, FWD, 16, FWD);
        check_period("bnd_new");

        // Reversal: 8 cycles of dead time, then reverse 10/127.
        send_frame(8'h0A, 8'h90);
        wait_phase(0);
        dead_n = 0;
        while (dead_n < 20 && enable12 === 1'b0 && {a1, a2} === COAST) begin
            @(negedge clk);
            dead_n++;
        end
        $display("reversal dead cycles=%0d a12=%b", dead_n, {a1, a2});
        check("rev_dead_len", dead_n, 8);
        check("rev_dir_after", {a1, a2}, REV);
        push_exp(10, REV, 16, FWD);
        check_period("rev10");

        // Watchdog expiry and recovery.
        send_frame(8'h0A, 8'h90);
        wait_fault("wdt1");
        check("wdt_fault", {fault, debug_light}, 2'b11);
        check("wdt_outputs", {enable12, a1, a2, enable34, a3, a4}, 6'b0);
        push_exp(0, COAST, 0, COAST);
        check_period("fault_off");
        check("fault_held", fault, 1'b1);
        send_frame(8'h90, 8'h90);
        check("fault_clear", {fault, debug_light}, 2'b00);
        push_exp(16, FWD, 16, FWD);
        check_period("recover16");

        // Reset in the middle of a dead-time window.
        send_frame(8'h10, 8'h90);
        wait_phase(0);
        repeat (3) @(negedge clk);
        check("pre_rst_dead", {enable12, a1, a2}, 3'b000);
        check("pre_rst_ch2", enable34, 1'b1);
        reset = 1'b1;
        @(negedge clk);
        check("rst_dead_outputs", {enable12, a1, a2, enable34, a3, a4}, 6'b0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        push_exp(0, COAST, 0, COAST);
        check_period("post_rst_a");
        push_exp(0, COAST, 0, COAST);
        check_period("post_rst_b");

        // Duty 0 after running: brake when enabled, coast otherwise.
        send_frame(8'h8A, 8'h00);
        push_exp(10, FWD, 0, COAST);
        check_period("pre_brake");
        send_frame(8'h00, 8'h00);
        push_exp(BRK_ON, BRK_A, 0, COAST);
        check_period("duty0_off");
        send_frame(8'h00, 8'h00);
        wait_fault("wdt2");
        check("wdt2_outputs", {enable12, a1, a2}, 3'b000);
        check("wdt2_fault", fault, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
